aes_decrypt_controller: RTL
===========================

# aes_decrypt_controller

Control FSM that sequences the iterative AES-128 decryption datapath behind the Avalon AES register file. It starts on the Start register (reg 14) and reports completion through the Done register (reg 15). In between it drives key expansion, then the initial AddRoundKey, nine full inverse rounds and the final round, issuing one datapath operation per clock. It holds no key or message data; it only produces load enables, operation selects and round-key indices.

## Interface
- KEYEXP_CYCLES, 10: clocks the key-expansion unit needs, ≥1.
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- AES_START  in  1  start request; level, mirrored from reg 14 bit 0.
- KEYEXP_EN  out  1  key-expansion enable; high throughout KEYEXP.
- LD_MSG  out  1  load encrypted message (regs 4-7) into the state register.
- LD_STATE  out  1  latch the datapath result into the state register.
- OP_SEL  out  2  datapath op: 0 ADDKEY, 1 INV_SHIFT, 2 INV_SUB, 3 INV_MIX.
- RKEY_SEL  out  4  round-key index 0..10 used by ADDKEY.
- MIX_COL  out  2  column processed by INV_MIX.
- BUSY  out  1  high in every state except IDLE and DONE.
- AES_DONE  out  1  operation complete; drives reg 15 bit 0.

## Operation
- States: IDLE, LOAD, KEYEXP, ADDKEY0, SHIFT, SUB, ADDKEY, MIX, DONE. All outputs are Moore (decoded from state and counters only).
- IDLE: all outputs 0. AES_START=1 moves to LOAD.
- LOAD: LD_MSG=1 for 1 cycle, then KEYEXP.
- KEYEXP: KEYEXP_EN=1 for exactly KEYEXP_CYCLES cycles, counted by a down-counter, then ADDKEY0.
- ADDKEY0: OP_SEL=ADDKEY, RKEY_SEL=10, LD_STATE=1. Round counter is set to 1, then SHIFT.
- SHIFT (OP_SEL=1), then SUB (OP_SEL=2), then ADDKEY (OP_SEL=0, RKEY_SEL=10−round). LD_STATE=1 in each.
- After ADDKEY: if round<10, go to MIX; if round=10, go to DONE.
- MIX: OP_SEL=3, LD_STATE=1, MIX_COL steps 0,1,2,3 on consecutive cycles. After column 3, round increments and the FSM returns to SHIFT.
- Round counter is 4 bits and never exceeds 10. MIX_COL wraps 3→0 on leaving MIX.
- DONE: AES_DONE=1 and all other outputs 0. Stay while AES_START=1. Go to IDLE on AES_START=0, so each start pulse gives one decryption and there is no auto-restart.
- Deassertion of AES_START while BUSY is ignored; the operation runs to completion.
- RESET in any state: next edge gives IDLE with all counters 0 and all outputs 0, including AES_DONE.

## Timing
- Reset values: every output is 0; state is IDLE.
- Let edge 0 be the clock at which AES_START is first sampled high in IDLE.
  - LD_MSG is high during cycle 1.
  - KEYEXP spans cycles 2..K+1, where K=KEYEXP_CYCLES.
  - ADDKEY0 is cycle K+2.
  - Each full round takes 7 cycles (SHIFT, SUB, ADDKEY, 4×MIX).
  - The final round takes 3 cycles.
- AES_DONE rises after edge K+68, so total latency is K+68 clocks (78 at default).
- AES_DONE falls 1 clock after AES_START is sampled low in DONE.
- RESET asserted together with AES_START: reset wins and the FSM stays IDLE.

## Structure
- Package aes_ctrl_pkg holds:
  - state enum aes_ctrl_state_t;
  - op enum aes_op_t {ADDKEY, INV_SHIFT, INV_SUB, INV_MIX} at widths 2'd0..3;
  - constant NUM_ROUNDS=10.
- This is a single module with one FSM plus three counters (keyexp, round, column). No sub-module is required.

## Test plan
- Reset mid-round: assert RESET during MIX with round=4 → next cycle state IDLE and all outputs 0. A subsequent start gives full K+68 latency.
- Nominal run, K=10: pulse AES_START high and hold it → LD_MSG in cycle 1, KEYEXP_EN in cycles 2..11, AES_DONE high after edge 78. Drop AES_START → AES_DONE low 1 clock later.
- Op trace: log (OP_SEL, RKEY_SEL, MIX_COL) per LD_STATE cycle → 67 entries:
  - entry 1 is ADDKEY/10;
  - entries 2..64 are 9 rounds of SHIFT, SUB, ADDKEY/(10−r), MIX 0..3;
  - entries 65..67 are SHIFT, SUB, ADDKEY/0.
- Start dropped mid-run: AES_START pulsed high for 1 cycle only → run still completes, AES_DONE pulses 1 cycle, returns to IDLE.
- Held start: AES_START kept high for 200 cycles → exactly one run (single LD_MSG), FSM stays in DONE.
- KEYEXP_CYCLES=1 build → AES_DONE after edge 69; KEYEXP_EN high exactly 1 cycle.

Source files
------------

// File: rtl/aes_decrypt_controller_pkg.sv
// Shared types and constants for the AES-128 decryption sequencer.
// The state enum, the datapath op encoding and the round count live here.
package aes_ctrl_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned RKEY_W     = 4;
  localparam int unsigned COL_W      = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_KEYEXP,
    S_ADDKEY0,
    S_SHIFT,
    S_SUB,
    S_ADDKEY,
    S_MIX,
    S_DONE
  } aes_ctrl_state_t;

  typedef enum logic [1:0] {
    ADDKEY    = 2'd0,
    INV_SHIFT = 2'd1,
    INV_SUB   = 2'd2,
    INV_MIX   = 2'd3
  } aes_op_t;

endpackage

// File: rtl/aes_decrypt_controller_if.sv
// Control bundle between the decryption sequencer (master) and the AES
// register file / datapath (slave).
interface aes_decrypt_controller_if;
  import aes_ctrl_pkg::*;

  logic              AES_START;
  logic              KEYEXP_EN;
  logic              LD_MSG;
  logic              LD_STATE;
  aes_op_t           OP_SEL;
  logic [RKEY_W-1:0] RKEY_SEL;
  logic [COL_W-1:0]  MIX_COL;
  logic              BUSY;
  logic              AES_DONE;

  modport master (
    input  AES_START,
    output KEYEXP_EN, LD_MSG, LD_STATE, OP_SEL, RKEY_SEL, MIX_COL, BUSY, AES_DONE
  );

  modport slave (
    output AES_START,
    input  KEYEXP_EN, LD_MSG, LD_STATE, OP_SEL, RKEY_SEL, MIX_COL, BUSY, AES_DONE
  );

endinterface

// File: rtl/aes_decrypt_controller.sv
// Sequencer for iterative AES-128 decryption: key expansion, initial AddRoundKey,
// nine full inverse rounds and the final round, one datapath op per clock.
module aes_decrypt_controller
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned KEYEXP_CYCLES = 10
) (
  input  logic                      CLK,
  input  logic                      RESET,
  aes_decrypt_controller_if.master  bus
);

  localparam int unsigned KE_W = (KEYEXP_CYCLES > 1) ? $clog2(KEYEXP_CYCLES) : 1;
  localparam logic [KE_W-1:0] KE_LOAD = KE_W'(KEYEXP_CYCLES - 1);

  aes_ctrl_state_t     state_q,  state_d;
  logic [KE_W-1:0]     ke_cnt_q, ke_cnt_d;
  logic [ROUND_W-1:0]  round_q,  round_d;
  logic [COL_W-1:0]    col_q,    col_d;

  logic                keyexp_en_q, keyexp_en_d;
  logic                ld_msg_q,    ld_msg_d;
  logic                ld_state_q,  ld_state_d;
  aes_op_t             op_sel_q,    op_sel_d;
  logic [RKEY_W-1:0]   rkey_sel_q,  rkey_sel_d;
  logic [COL_W-1:0]    mix_col_q,   mix_col_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      ke_cnt_q    <= '0;
      round_q     <= '0;
      col_q       <= '0;
      keyexp_en_q <= 1'b0;
      ld_msg_q    <= 1'b0;
      ld_state_q  <= 1'b0;
      op_sel_q    <= ADDKEY;
      rkey_sel_q  <= '0;
      mix_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ke_cnt_q    <= ke_cnt_d;
      round_q     <= round_d;
      col_q       <= col_d;
      keyexp_en_q <= keyexp_en_d;
      ld_msg_q    <= ld_msg_d;
      ld_state_q  <= ld_state_d;
      op_sel_q    <= op_sel_d;
      rkey_sel_q  <= rkey_sel_d;
      mix_col_q   <= mix_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state / counters, then outputs decoded from the next state so the
  // registered outputs line up with the state they describe
  always_comb begin
    state_d     = state_q;
    ke_cnt_d    = ke_cnt_q;
    round_d     = round_q;
    col_d       = col_q;
    keyexp_en_d = 1'b0;
    ld_msg_d    = 1'b0;
    ld_state_d  = 1'b0;
    op_sel_d    = ADDKEY;
    rkey_sel_d  = '0;
    mix_col_d   = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        round_d = '0;
        col_d   = '0;
        if (bus.AES_START) state_d = S_LOAD;
      end
      S_LOAD: begin
        ke_cnt_d = KE_LOAD;
        state_d  = S_KEYEXP;
      end
      S_KEYEXP: begin
        if (ke_cnt_q == '0) state_d  = S_ADDKEY0;
        else                ke_cnt_d = ke_cnt_q - KE_W'(1);
      end
      S_ADDKEY0: begin
        round_d = ROUND_W'(1);
        state_d = S_SHIFT;
      end
      S_SHIFT:  state_d = S_SUB;
      S_SUB:    state_d = S_ADDKEY;
      S_ADDKEY: state_d = (round_q == ROUND_W'(NUM_ROUNDS)) ? S_DONE : S_MIX;
      S_MIX: begin
        col_d = col_q + COL_W'(1);
        if (col_q == COL_W'(3)) begin
          round_d = round_q + ROUND_W'(1);
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        round_d = '0;
        if (!bus.AES_START) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_LOAD:    ld_msg_d    = 1'b1;
      S_KEYEXP:  keyexp_en_d = 1'b1;
      S_ADDKEY0: begin
        ld_state_d = 1'b1;
        op_sel_d   = ADDKEY;
        rkey_sel_d = RKEY_W'(NUM_ROUNDS);
      end
      S_SHIFT: begin
        ld_state_d = 1'b1;
        op_sel_d   = INV_SHIFT;
      end
      S_SUB: begin
        ld_state_d = 1'b1;
        op_sel_d   = INV_SUB;
      end
      S_ADDKEY: begin
        ld_state_d = 1'b1;
        op_sel_d   = ADDKEY;
        rkey_sel_d = RKEY_W'(NUM_ROUNDS) - RKEY_W'(round_d);
      end
      S_MIX: begin
        ld_state_d = 1'b1;
        op_sel_d   = INV_MIX;
        mix_col_d  = col_d;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  assign bus.KEYEXP_EN = keyexp_en_q;
  assign bus.LD_MSG    = ld_msg_q;
  assign bus.LD_STATE  = ld_state_q;
  assign bus.OP_SEL    = op_sel_q;
  assign bus.RKEY_SEL  = rkey_sel_q;
  assign bus.MIX_COL   = mix_col_q;
  assign bus.BUSY      = busy_q;
  assign bus.AES_DONE  = done_q;

endmodule
